// File: rtl/pitch_pkg.sv
// Shared constants and types for the microphone pitch detector.
// Holds parameter defaults, datapath widths and the measurement FSM state type.
package pitch_pkg;

  localparam int unsigned MIC_W    = 12;
  localparam int unsigned PERIOD_W = 10;

  localparam int unsigned MID_DEFAULT        = 2048;
  localparam int unsigned HYST_DEFAULT       = 64;
  localparam int unsigned MIN_PERIOD_DEFAULT = 8;
  localparam int unsigned MAX_PERIOD_DEFAULT = 1023;
  localparam int unsigned AVG_LOG2_DEFAULT   = 2;

  typedef enum logic [0:0] {
    StIdle,
    StMeasure
  } state_e;

endpackage

// File: rtl/period_averager.sv
// Moving average over the last 2^AVG_LOG2 accepted periods.
// avg/avg_valid are combinational on push; the caller registers them.
module period_averager
  import pitch_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                push,
  input  logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] avg,
  output logic                avg_valid,
  output logic                full
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = PERIOD_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PERIOD_W-1:0] hist_q [DEPTH];
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_new;
  logic [CNT_W-1:0]    fill_q;
  logic [CNT_W-1:0]    fill_next;

  // Unfilled slots are zero, so subtracting the oldest entry is always correct.
  always_comb begin
    sum_new   = sum_q + SUM_W'(period) - SUM_W'(hist_q[DEPTH-1]);
    full      = (fill_q == FULL_CNT);
    fill_next = full ? fill_q : fill_q + 1'b1;
    avg       = sum_new[SUM_W-1:AVG_LOG2];
    avg_valid = push && (fill_next == FULL_CNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (push) begin
      hist_q[0] <= period;
      for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
      sum_q  <= sum_new;
      fill_q <= fill_next;
    end
  end

endmodule

// File: rtl/mic_pitch_detector.sv
// Pitch detector: hysteretic zero-crossing tracker measures the sample count between
// rising crossings and reports a moving average of accepted periods.
module mic_pitch_detector
  import pitch_pkg::*;
#(
  parameter int unsigned MID        = MID_DEFAULT,
  parameter int unsigned HYST       = HYST_DEFAULT,
  parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT,
  parameter int unsigned MAX_PERIOD = MAX_PERIOD_DEFAULT,
  parameter int unsigned AVG_LOG2   = AVG_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MIC_W-1:0]    mic,
  input  logic                mic_valid,
  output logic [PERIOD_W-1:0] period_avg,
  output logic                pitch_valid,
  output logic                voiced
);

  localparam logic [MIC_W-1:0]    HI_TH = MIC_W'(MID + HYST);
  localparam logic [MIC_W-1:0]    LO_TH = MIC_W'(MID - HYST);
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);

  state_e              state_q, state_d;
  logic                pol_q, pol_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] cnt_inc;
  logic                above, below, crossing;
  logic                accept, timeout, avg_clear;
  logic [PERIOD_W-1:0] avg;
  logic                avg_valid, avg_full;
  logic [PERIOD_W-1:0] period_avg_q;
  logic                pitch_valid_q, voiced_q, voiced_d;

  always_comb begin
    above    = (mic >= HI_TH);
    below    = (mic <= LO_TH);
    crossing = mic_valid && !pol_q && above;
    cnt_inc  = cnt_q + 1'b1;

    pol_d = pol_q;
    if (mic_valid) begin
      if (above)      pol_d = 1'b1;
      else if (below) pol_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    timeout   = 1'b0;
    avg_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (crossing) begin
          cnt_d     = '0;
          avg_clear = 1'b1;
          state_d   = StMeasure;
        end
      end
      StMeasure: begin
        if (mic_valid) begin
          if (crossing && cnt_inc >= MIN_P && cnt_inc < MAX_P) begin
            accept = 1'b1;
            cnt_d  = '0;
          end else begin
            // Short crossings are noise and just keep counting toward timeout.
            cnt_d = cnt_inc;
            if (cnt_inc >= MAX_P) begin
              timeout   = 1'b1;
              avg_clear = 1'b1;
              state_d   = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  period_averager #(
    .AVG_LOG2(AVG_LOG2)
  ) u_averager (
    .clk      (clk),
    .reset    (reset),
    .clear    (avg_clear),
    .push     (accept),
    .period   (cnt_inc),
    .avg      (avg),
    .avg_valid(avg_valid),
    .full     (avg_full)
  );

  // Voiced holds while the averager stays full; any clear (timeout) drops it.
  assign voiced_d = !avg_clear && (avg_valid || (voiced_q && avg_full));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      pol_q         <= 1'b0;
      cnt_q         <= '0;
      period_avg_q  <= '0;
      pitch_valid_q <= 1'b0;
      voiced_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pol_q         <= pol_d;
      cnt_q         <= cnt_d;
      pitch_valid_q <= avg_valid;
      voiced_q      <= voiced_d;
      if (avg_valid) period_avg_q <= avg;
    end
  end

  assign period_avg  = period_avg_q;
  assign pitch_valid = pitch_valid_q;
  assign voiced      = voiced_q;

endmodule

// File: tb/tb_mic_pitch_detector.sv
// Directed bench for mic_pitch_detector: lock, timeout, hysteresis, sparse strobes, reset.
module tb_mic_pitch_detector;
  import pitch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] mic = '0;
  logic        mic_valid = 1'b0;
  logic [9:0]  period_avg;
  logic        pitch_valid;
  logic        voiced;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;

  mic_pitch_detector dut (
    .clk        (clk),
    .reset      (reset),
    .mic        (mic),
    .mic_valid  (mic_valid),
    .period_avg (period_avg),
    .pitch_valid(pitch_valid),
    .voiced     (voiced)
  );

  always #5 clk = ~clk;

  // One clock: drive at negedge, observe 1 unit after the rising edge.
  task automatic step(input logic [11:0] v, input logic vld);
    @(negedge clk);
    mic = v;
    mic_valid = vld;
    @(posedge clk);
    #1;
    if (pitch_valid) pv_cnt++;
  endtask

  // Valid sample followed by gap strobe-low cycles carrying inverted garbage.
  task automatic send(input logic [11:0] v, input int gap);
    step(v, 1'b1);
    for (int g = 0; g < gap; g++) step(~v, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mic = '0;
    mic_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pv_cnt = 0;
  endtask

  // Periods of [low half][high half]; rising crossing at first high sample.
  task automatic run_periods(input int n, input int half, input int gap, input bit band);
    logic [11:0] v;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < half; i++) begin
        v = (i == 0 || !band) ? 12'd1000 : ((i % 2) ? 12'd2098 : 12'd1998);
        send(v, gap);
      end
      for (int i = 0; i < half; i++) begin
        if (i == 0) v = 12'd3000;
        else if (band && (p == 2 || p == 4) && i == 1) v = 12'd1000;
        else if (band && (p == 2 || p == 4) && i >= 2 && i <= 4) v = 12'd3000;
        else v = band ? ((i % 2) ? 12'd2098 : 12'd1998) : 12'd3000;
        send(v, gap);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (period_avg !== 10'd0) begin
      errors++; $display("FAIL reset_period_avg: got %0d want 0", period_avg);
    end
    checks++;
    if (pitch_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pitch_valid: got %b want 0", pitch_valid);
    end
    checks++;
    if (voiced !== 1'b0) begin
      errors++; $display("FAIL reset_voiced: got %b want 0", voiced);
    end
  endtask

  task automatic test_lock();
    do_reset();
    run_periods(4, 20, 0, 1'b0);
    checks++;
    if (pv_cnt !== 0) begin
      errors++; $display("FAIL lock_early_pv: got %0d pulses want 0", pv_cnt);
    end
    for (int i = 0; i < 20; i++) send(12'd1000, 0);
    send(12'd3000, 0);
    checks++;
    if (pitch_valid !== 1'b1) begin
      errors++; $display("FAIL lock_pv: got %b want 1", pitch_valid);
    end
    checks++;
    if (period_avg !== 10'd40) begin
      errors++; $display("FAIL lock_avg: got %0d want 40", period_avg);
    end
    checks++;
    if (voiced !== 1'b1) begin
      errors++; $display("FAIL lock_voiced: got %b want 1", voiced);
    end
  endtask

  // Continues from test_lock: last accept was the final sample sent there.
  task automatic test_timeout();
    send(12'd3000, 0);
    checks++;
    if (pitch_valid !== 1'b0) begin
      errors++; $display("FAIL pv_one_cycle: got %b want 0", pitch_valid);
    end
    for (int i = 2; i <= 1022; i++) send(12'd1000, 0);
    checks++;
    if (voiced !== 1'b1) begin
      errors++; $display("FAIL timeout_early: voiced %b want 1 after 1022 samples", voiced);
    end
    send(12'd1000, 0);
    checks++;
    if (voiced !== 1'b0) begin
      errors++; $display("FAIL timeout_voiced: got %b want 0 after 1023 samples", voiced);
    end
    checks++;
    if (dut.state_q !== StIdle) begin
      errors++; $display("FAIL timeout_state: got %0d want %0d", dut.state_q, StIdle);
    end
    checks++;
    if (period_avg !== 10'd40) begin
      errors++; $display("FAIL timeout_hold_avg: got %0d want 40", period_avg);
    end
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 2000; i++) send(12'd2048, 0);
    checks++;
    if (pv_cnt !== 0) begin
      errors++; $display("FAIL const_pv: got %0d pulses want 0", pv_cnt);
    end
    checks++;
    if (voiced !== 1'b0) begin
      errors++; $display("FAIL const_voiced: got %b want 0", voiced);
    end
  endtask

  task automatic test_hysteresis();
    do_reset();
    // 6 crossings -> 5 accepts -> pulses on accepts 4 and 5.
    run_periods(6, 20, 0, 1'b1);
    checks++;
    if (pv_cnt !== 2) begin
      errors++; $display("FAIL hyst_pv: got %0d pulses want 2", pv_cnt);
    end
    checks++;
    if (period_avg !== 10'd40) begin
      errors++; $display("FAIL hyst_avg: got %0d want 40", period_avg);
    end
    checks++;
    if (voiced !== 1'b1) begin
      errors++; $display("FAIL hyst_voiced: got %b want 1", voiced);
    end
  endtask

  task automatic test_sparse_valid();
    do_reset();
    run_periods(5, 20, 2, 1'b0);
    checks++;
    if (pv_cnt !== 1) begin
      errors++; $display("FAIL sparse_pv: got %0d pulse cycles want 1", pv_cnt);
    end
    checks++;
    if (period_avg !== 10'd40) begin
      errors++; $display("FAIL sparse_avg: got %0d want 40", period_avg);
    end
    checks++;
    if (voiced !== 1'b1) begin
      errors++; $display("FAIL sparse_voiced: got %b want 1", voiced);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_periods(8, 20, 0, 1'b0);
    for (int i = 0; i < 7; i++) send(12'd1000, 0);
    checks++;
    if (voiced !== 1'b1 || period_avg !== 10'd40) begin
      errors++; $display("FAIL mid_pre: voiced %b avg %0d want 1/40", voiced, period_avg);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (period_avg !== 10'd0 || pitch_valid !== 1'b0 || voiced !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: avg %0d pv %b voiced %b want 0/0/0",
               period_avg, pitch_valid, voiced);
    end
    @(negedge clk);
    reset = 1'b1;
    pv_cnt = 0;
    run_periods(4, 15, 0, 1'b0);
    checks++;
    if (pv_cnt !== 0) begin
      errors++; $display("FAIL mid_stale: got %0d pulses after 3 accepts want 0", pv_cnt);
    end
    for (int i = 0; i < 15; i++) send(12'd1000, 0);
    send(12'd3000, 0);
    checks++;
    if (pitch_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pv: got %b want 1", pitch_valid);
    end
    checks++;
    if (period_avg !== 10'd30) begin
      errors++; $display("FAIL mid_avg: got %0d want 30", period_avg);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_timeout();
    test_constant();
    test_hysteresis();
    test_sparse_valid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
